// File: rtl/step_sequencer.sv
// -----------------------------------------------------------------------------
// step_sequencer
//
// Runs one operand through up to NUM_STEPS external compute steps in ascending
// index order. A per-job mask selects which steps take part. Each step is
// launched with a single-cycle step_start pulse, and its result is awaited in
// WAIT. A per-step timeout and an abort input can end a job early. Every job
// ends with a single-cycle done pulse and a status code.
//
// Handshakes:
//   start/busy : a job is accepted on any cycle where start=1 and busy=0.
//                data_in, step_mask and timeout_lim are sampled on that edge.
//                start while busy=1 is dropped and is not queued.
//   step i     : step_start[i] is a one-cycle launch pulse that qualifies
//                step_data. step_done[i] is a one-cycle pulse that qualifies
//                step_out[i]. Only the done bit of the active step counts.
//   done       : a one-cycle pulse. data_out and status are valid with it and
//                hold until the next job ends.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        job request
//   data_in      operand (DATA_W)
//   step_mask    per-job step enables (NUM_STEPS)
//   timeout_lim  maximum WAIT cycles per step, 0 = no timeout (TO_W)
//   abort        ends the running job with status ABORT
//   step_start   one-hot launch pulses (NUM_STEPS)
//   step_data    operand driven to the active step (work register)
//   step_out     flattened step results, step i at [i*DATA_W +: DATA_W]
//   step_done    per-step result-valid pulses (NUM_STEPS)
//   busy         a job is in progress
//   data_out     result register
//   done         job-complete pulse
//   status       00 OK, 01 TIMEOUT, 10 ABORT
//   cur_step     index of the active step, 0 when idle (debug view of the FSM)
// -----------------------------------------------------------------------------
module step_sequencer #(
   parameter  int DATA_W    = 8,
   parameter  int NUM_STEPS = 4,
   parameter  int TO_W      = 8,
   localparam int IDX_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [DATA_W-1:0]             data_in,
   input  logic [NUM_STEPS-1:0]          step_mask,
   input  logic [TO_W-1:0]               timeout_lim,
   input  logic                          abort,
   output logic [NUM_STEPS-1:0]          step_start,
   output logic [DATA_W-1:0]             step_data,
   input  logic [NUM_STEPS*DATA_W-1:0]   step_out,
   input  logic [NUM_STEPS-1:0]          step_done,
   output logic                          busy,
   output logic [DATA_W-1:0]             data_out,
   output logic                          done,
   output logic [1:0]                    status,
   output logic [IDX_W-1:0]              cur_step
);

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_TIMEOUT = 2'b01;
   localparam logic [1:0] ST_ABORT   = 2'b10;

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

   state_t                 state, state_nxt;
   logic [DATA_W-1:0]      work, work_nxt, data_out_nxt;
   logic [NUM_STEPS-1:0]   mask, mask_nxt, mask_left, step_start_nxt;
   logic [TO_W-1:0]        lim, lim_nxt, cnt, cnt_nxt, cnt_inc;
   logic [IDX_W-1:0]       cur_nxt;
   logic                   done_nxt;
   logic [1:0]             status_nxt;
   logic [DATA_W-1:0]      step_res [NUM_STEPS];

   for (genvar g = 0; g < NUM_STEPS; g++) begin : g_unpack
      assign step_res[g] = step_out[g*DATA_W +: DATA_W];
   end

   // Index of the lowest set bit. Completed steps are cleared from the mask,
   // so the lowest remaining bit is always the next higher enabled step.
   function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_STEPS-1:0] m);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = NUM_STEPS - 1; i >= 0; i--) begin
         if (m[i]) r = IDX_W'(i);
      end
      return r;
   endfunction

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         work       <= '0;
         mask       <= '0;
         lim        <= '0;
         cnt        <= '0;
         cur_step   <= '0;
         data_out   <= '0;
         status     <= ST_OK;
         done       <= 1'b0;
         step_start <= '0;
      end else begin
         state      <= state_nxt;
         work       <= work_nxt;
         mask       <= mask_nxt;
         lim        <= lim_nxt;
         cnt        <= cnt_nxt;
         cur_step   <= cur_nxt;
         data_out   <= data_out_nxt;
         status     <= status_nxt;
         done       <= done_nxt;
         step_start <= step_start_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt           = state;
      work_nxt            = work;
      mask_nxt            = mask;
      lim_nxt             = lim;
      cnt_nxt             = cnt;
      cur_nxt             = cur_step;
      data_out_nxt        = data_out;
      status_nxt          = status;
      done_nxt            = 1'b0;
      step_start_nxt      = '0;
      mask_left           = mask;
      mask_left[cur_step] = 1'b0;
      // Saturating increment: the counter holds at all-ones rather than wrap.
      cnt_inc             = (cnt == '1) ? cnt : cnt + 1'b1;

      case (state)
         IDLE: begin
            if (start) begin
               work_nxt = data_in;
               mask_nxt = step_mask;
               lim_nxt  = timeout_lim;
               cnt_nxt  = '0;
               if (step_mask == '0) begin
                  // Nothing to run: the operand passes straight through.
                  data_out_nxt = data_in;
                  done_nxt     = 1'b1;
                  status_nxt   = ST_OK;
               end else begin
                  cur_nxt                 = lowest_set(step_mask);
                  step_start_nxt[cur_nxt] = 1'b1;
                  state_nxt               = LAUNCH;
               end
            end
         end

         LAUNCH: begin
            if (abort) begin
               done_nxt   = 1'b1;
               status_nxt = ST_ABORT;
               cur_nxt    = '0;
               state_nxt  = IDLE;
            end else begin
               cnt_nxt   = '0;
               state_nxt = WAIT;
            end
         end

         WAIT: begin
            // Priority: abort, then the active step's done, then timeout.
            if (abort) begin
               done_nxt   = 1'b1;
               status_nxt = ST_ABORT;
               cur_nxt    = '0;
               state_nxt  = IDLE;
            end else if (step_done[cur_step]) begin
               work_nxt = step_res[cur_step];
               mask_nxt = mask_left;
               if (mask_left != '0) begin
                  cur_nxt                 = lowest_set(mask_left);
                  step_start_nxt[cur_nxt] = 1'b1;
                  state_nxt               = LAUNCH;
               end else begin
                  data_out_nxt = step_res[cur_step];
                  done_nxt     = 1'b1;
                  status_nxt   = ST_OK;
                  cur_nxt      = '0;
                  state_nxt    = IDLE;
               end
            end else begin
               cnt_nxt = cnt_inc;
               if ((lim != '0) && (cnt_inc == lim)) begin
                  // The result is the output of the last completed step.
                  data_out_nxt = work;
                  done_nxt     = 1'b1;
                  status_nxt   = ST_TIMEOUT;
                  cur_nxt      = '0;
                  state_nxt    = IDLE;
               end
            end
         end

         default: begin
            state_nxt = IDLE;
            cur_nxt   = '0;
         end
      endcase
   end

   // Outputs derived from state
   always_comb begin
      busy      = (state != IDLE);
      step_data = work;
   end

endmodule

// File: tb/tb_step_sequencer.sv
// -----------------------------------------------------------------------------
// tb_step_sequencer
//
// Bench for step_sequencer with four step models. Each model returns its
// operand plus 8'h10 three cycles after its launch pulse. A negedge monitor
// logs every launch pulse and every done pulse. Each scenario task pushes the
// expected launches and results, including their absolute cycle numbers, into
// queues. score() then compares them in order against the monitor log.
// Cycle k of a job is the cycle in which cyc == t0 + k, where t0 is the value
// of cyc just before the edge that accepts start.
// -----------------------------------------------------------------------------
module tb_step_sequencer;

   localparam int DATA_W    = 8;
   localparam int NUM_STEPS = 4;
   localparam int TO_W      = 8;

   logic                        clk         = 1'b0;
   logic                        rst_n       = 1'b0;
   logic                        start       = 1'b0;
   logic                        abort       = 1'b0;
   logic [DATA_W-1:0]           data_in     = '0;
   logic [NUM_STEPS-1:0]        step_mask   = '0;
   logic [TO_W-1:0]             timeout_lim = '0;
   logic [NUM_STEPS-1:0]        step_start;
   logic [DATA_W-1:0]           step_data;
   logic [NUM_STEPS*DATA_W-1:0] step_out;
   logic [NUM_STEPS-1:0]        step_done;
   logic                        busy;
   logic [DATA_W-1:0]           data_out;
   logic                        done;
   logic [1:0]                  status;
   logic [1:0]                  cur_step;

   // Step model controls
   logic [NUM_STEPS-1:0]        resp_en  = '1;
   logic [NUM_STEPS-1:0]        spurious = '0;

   int cyc       = 0;
   int tests_run = 0;
   int failures  = 0;
   int launch_rd = 0;
   int done_rd   = 0;
   logic [DATA_W-1:0] last_data = '0;

   // Expected queues, filled by the scenario tasks
   logic [NUM_STEPS-1:0] exp_launch_q[$];
   int                   exp_launch_cyc_q[$];
   logic [DATA_W-1:0]    exp_data_q[$];
   logic [1:0]           exp_status_q[$];
   int                   exp_done_cyc_q[$];

   // Observed log, written only by the monitor
   logic [NUM_STEPS-1:0] obs_launch_vec[$];
   int                   obs_launch_cyc[$];
   logic [DATA_W-1:0]    obs_done_data[$];
   logic [1:0]           obs_done_status[$];
   logic                 obs_done_busy[$];
   int                   obs_done_cyc[$];

   step_sequencer #(
      .DATA_W    (DATA_W),
      .NUM_STEPS (NUM_STEPS),
      .TO_W      (TO_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .data_in     (data_in),
      .step_mask   (step_mask),
      .timeout_lim (timeout_lim),
      .abort       (abort),
      .step_start  (step_start),
      .step_data   (step_data),
      .step_out    (step_out),
      .step_done   (step_done),
      .busy        (busy),
      .data_out    (data_out),
      .done        (done),
      .status      (status),
      .cur_step    (cur_step)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- step models ----------------
   logic [2:0]        sr  [NUM_STEPS];
   logic [DATA_W-1:0] res [NUM_STEPS];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_STEPS; i++) begin
            sr[i]  <= '0;
            res[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_STEPS; i++) begin
            sr[i] <= {sr[i][1:0], step_start[i]};
            if (step_start[i]) res[i] <= step_data + 8'h10;
         end
      end
   end

   always_comb begin
      step_out  = '0;
      step_done = '0;
      for (int i = 0; i < NUM_STEPS; i++) begin
         step_out[i*DATA_W +: DATA_W] = res[i];
         step_done[i] = (sr[i][2] & resp_en[i]) | spurious[i];
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         if (step_start !== '0) begin
            obs_launch_vec.push_back(step_start);
            obs_launch_cyc.push_back(cyc);
         end
         if (done !== 1'b0) begin
            obs_done_data.push_back(data_out);
            obs_done_status.push_back(status);
            obs_done_busy.push_back(busy);
            obs_done_cyc.push_back(cyc);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_cycle(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_job(input logic [DATA_W-1:0] d, input logic [NUM_STEPS-1:0] m,
                            input logic [TO_W-1:0] l, output int t0);
      @(posedge clk);
      #1;
      data_in     = d;
      step_mask   = m;
      timeout_lim = l;
      start       = 1'b1;
      t0          = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic exp_launch(input int idx, input int at);
      exp_launch_q.push_back(NUM_STEPS'(1) << idx);
      exp_launch_cyc_q.push_back(at);
   endtask

   task automatic exp_done(input logic [DATA_W-1:0] d, input logic [1:0] st, input int at);
      exp_data_q.push_back(d);
      exp_status_q.push_back(st);
      exp_done_cyc_q.push_back(at);
   endtask

   task automatic wait_done(input int n);
      int budget;
      budget = 60;
      while ((obs_done_cyc.size() - done_rd) < n && budget > 0) begin
         @(posedge clk);
         #1;
         budget--;
      end
      tests_run++;
      if ((obs_done_cyc.size() - done_rd) < n) begin
         failures++;
         $display("FAIL wait_done: got %0d done pulses, expected %0d within 60 cycles",
                  obs_done_cyc.size() - done_rd, n);
      end
      // Let any extra pulses show up before scoring.
      wait_cycle(cyc + 4);
   endtask

   // ---------------- scoreboard ----------------
   task automatic score(input string tag);
      logic [NUM_STEPS-1:0] e_vec;
      logic [DATA_W-1:0]    e_dat;
      logic [1:0]           e_st;
      int                   e_cyc;
      while (launch_rd < obs_launch_vec.size()) begin
         tests_run++;
         if (exp_launch_q.size() == 0) begin
            failures++;
            $display("FAIL %s_launch: got step_start=%b at cycle %0d, expected no launch",
                     tag, obs_launch_vec[launch_rd], obs_launch_cyc[launch_rd]);
         end else begin
            e_vec = exp_launch_q.pop_front();
            e_cyc = exp_launch_cyc_q.pop_front();
            if (obs_launch_vec[launch_rd] !== e_vec || obs_launch_cyc[launch_rd] != e_cyc) begin
               failures++;
               $display("FAIL %s_launch: got step_start=%b at cycle %0d, expected %b at cycle %0d",
                        tag, obs_launch_vec[launch_rd], obs_launch_cyc[launch_rd], e_vec, e_cyc);
            end
         end
         launch_rd++;
      end
      tests_run++;
      if (exp_launch_q.size() != 0) begin
         failures++;
         $display("FAIL %s_missing_launch: got 0 further launches, expected %0d more",
                  tag, exp_launch_q.size());
      end
      exp_launch_q.delete();
      exp_launch_cyc_q.delete();

      while (done_rd < obs_done_cyc.size()) begin
         tests_run++;
         if (exp_data_q.size() == 0) begin
            failures++;
            $display("FAIL %s_done: got done pulse at cycle %0d, expected none",
                     tag, obs_done_cyc[done_rd]);
         end else begin
            e_dat = exp_data_q.pop_front();
            e_st  = exp_status_q.pop_front();
            e_cyc = exp_done_cyc_q.pop_front();
            if (obs_done_data[done_rd] !== e_dat || obs_done_status[done_rd] !== e_st ||
                obs_done_cyc[done_rd] != e_cyc || obs_done_busy[done_rd] !== 1'b0) begin
               failures++;
               $display("FAIL %s_done: got data=%h status=%b cycle=%0d busy=%b, expected data=%h status=%b cycle=%0d busy=0",
                        tag, obs_done_data[done_rd], obs_done_status[done_rd], obs_done_cyc[done_rd],
                        obs_done_busy[done_rd], e_dat, e_st, e_cyc);
            end
         end
         done_rd++;
      end
      tests_run++;
      if (exp_data_q.size() != 0) begin
         failures++;
         $display("FAIL %s_missing_done: got 0 further done pulses, expected %0d more",
                  tag, exp_data_q.size());
      end
      exp_data_q.delete();
      exp_status_q.delete();
      exp_done_cyc_q.delete();
   endtask

   // ---------------- scenarios ----------------
   task automatic check_outputs_zero(input string tag);
      tests_run++;
      if (step_start !== '0 || busy !== 1'b0 || done !== 1'b0 || status !== 2'b00 ||
          data_out !== '0 || step_data !== '0 || cur_step !== '0) begin
         failures++;
         $display("FAIL %s: got step_start=%b busy=%b done=%b status=%b data_out=%h step_data=%h cur_step=%0d, expected all 0",
                  tag, step_start, busy, done, status, data_out, step_data, cur_step);
      end
   endtask

   task automatic test_reset;
      #12;
      check_outputs_zero("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_cycle(cyc + 2);
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_release: got busy=%b done=%b, expected 0 0", busy, done);
      end
   endtask

   task automatic test_all_steps;
      int t0;
      start_job(8'h05, 4'b1111, 8'd0, t0);
      for (int i = 0; i < 4; i++) exp_launch(i, t0 + 1 + 4 * i);
      exp_done(8'h45, 2'b00, t0 + 17);
      wait_done(1);
      score("all_steps");
      last_data = 8'h45;
   endtask

   task automatic test_sparse;
      int t0;
      start_job(8'h05, 4'b0101, 8'd0, t0);
      exp_launch(0, t0 + 1);
      exp_launch(2, t0 + 5);
      exp_done(8'h25, 2'b00, t0 + 9);
      wait_done(1);
      score("sparse");
      last_data = 8'h25;
   endtask

   task automatic test_empty_mask;
      int t0;
      start_job(8'hA7, 4'b0000, 8'd0, t0);
      tests_run++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL empty_busy: got busy=%b, expected 0", busy);
      end
      exp_done(8'hA7, 2'b00, t0 + 1);
      wait_done(1);
      score("empty_mask");
      last_data = 8'hA7;
   endtask

   task automatic test_timeout;
      int t0;
      resp_en = 4'b1101;
      start_job(8'h05, 4'b1111, 8'd8, t0);
      exp_launch(0, t0 + 1);
      exp_launch(1, t0 + 5);
      exp_done(8'h15, 2'b01, t0 + 14);
      wait_done(1);
      resp_en = 4'b1111;
      score("timeout");
      last_data = 8'h15;
   endtask

   task automatic test_abort_vs_done;
      int t0;
      start_job(8'h05, 4'b1111, 8'd0, t0);
      exp_launch(0, t0 + 1);
      exp_launch(1, t0 + 5);
      exp_launch(2, t0 + 9);
      // Step 2 reports in cycle 12; abort lands in the same cycle.
      wait_cycle(t0 + 12);
      abort = 1'b1;
      wait_cycle(t0 + 13);
      abort = 1'b0;
      exp_done(last_data, 2'b10, t0 + 13);
      wait_done(1);
      score("abort_vs_done");
   endtask

   task automatic test_spurious_done;
      int t0;
      start_job(8'h05, 4'b1111, 8'd0, t0);
      wait_cycle(t0 + 6);
      spurious = 4'b1000;
      wait_cycle(t0 + 7);
      spurious = 4'b0000;
      for (int i = 0; i < 4; i++) exp_launch(i, t0 + 1 + 4 * i);
      exp_done(8'h45, 2'b00, t0 + 17);
      wait_done(1);
      score("spurious");
      last_data = 8'h45;
   endtask

   task automatic test_start_while_busy;
      int t0;
      start_job(8'h05, 4'b0011, 8'd0, t0);
      wait_cycle(t0 + 3);
      data_in   = 8'h80;
      step_mask = 4'b1111;
      start     = 1'b1;
      wait_cycle(t0 + 4);
      start = 1'b0;
      exp_launch(0, t0 + 1);
      exp_launch(1, t0 + 5);
      exp_done(8'h25, 2'b00, t0 + 9);
      wait_done(1);
      score("busy_start");
      last_data = 8'h25;
   endtask

   task automatic test_back_to_back;
      int t0;
      start_job(8'h01, 4'b0001, 8'd0, t0);
      exp_launch(0, t0 + 1);
      exp_done(8'h11, 2'b00, t0 + 5);
      // New request in the very cycle done is high.
      wait_cycle(t0 + 5);
      data_in   = 8'h33;
      step_mask = 4'b0000;
      start     = 1'b1;
      wait_cycle(t0 + 6);
      start = 1'b0;
      exp_done(8'h33, 2'b00, t0 + 6);
      wait_done(2);
      score("back_to_back");
      last_data = 8'h33;
   endtask

   task automatic test_reset_mid_job;
      int t0;
      start_job(8'h05, 4'b1111, 8'd0, t0);
      exp_launch(0, t0 + 1);
      exp_launch(1, t0 + 5);
      wait_cycle(t0 + 7);
      tests_run++;
      if (busy !== 1'b1 || cur_step !== 2'd1) begin
         failures++;
         $display("FAIL mid_job_state: got busy=%b cur_step=%0d, expected 1 1", busy, cur_step);
      end
      rst_n = 1'b0;
      #1;
      check_outputs_zero("reset_mid_job");
      wait_cycle(cyc + 2);
      rst_n = 1'b1;
      score("reset_mid_job");
      last_data = '0;
      start_job(8'h05, 4'b0101, 8'd0, t0);
      exp_launch(0, t0 + 1);
      exp_launch(2, t0 + 5);
      exp_done(8'h25, 2'b00, t0 + 9);
      wait_done(1);
      score("after_reset");
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_all_steps();
      test_sparse();
      test_empty_mask();
      test_timeout();
      test_abort_vs_done();
      test_spurious_done();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid_job();
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
Parametrised successor to the fixed four-stage step controller. It runs one operand through up to NUM_STEPS external compute steps in ascending index order. Each step can be enabled per job by a mask. The block adds a start/busy handshake, single-cycle step launch pulses, a per-step timeout and an abort input, and reports a completion status with the result. It sits between the request source and a bank of step modules that share one operand bus.

Parameters:
DATA_W, 8, operand/result width
NUM_STEPS, 4, number of attached step modules (1..16)
TO_W, 8, width of the timeout limit and timeout counter
(derived IDX_W = max(1, clog2(NUM_STEPS)); not overridable)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  job request; accepted only when busy=0
data_in  in  DATA_W  operand; sampled with accepted start
step_mask  in  NUM_STEPS  bit i=1 enables step i; sampled with accepted start
timeout_lim  in  TO_W  max WAIT cycles per step; 0 disables timeout; sampled with accepted start
abort  in  1  terminate the running job
step_start  out  NUM_STEPS  one-hot, single-cycle launch pulse to step i
step_data  out  DATA_W  operand to the active step (work register)
step_out  in  NUM_STEPS*DATA_W  flattened step results; step i occupies bits [i*DATA_W +: DATA_W]
step_done  in  NUM_STEPS  step i result valid, 1-cycle pulse
busy  out  1  job in progress
data_out  out  DATA_W  result register
done  out  1  single-cycle job-complete pulse
status  out  2  valid with done: 00 OK, 01 TIMEOUT, 10 ABORT
cur_step  out  IDX_W  index of the active step (debug); 0 when idle

Behaviour:
- Reset (async, immediate): state=IDLE; every output and internal register is 0, including step_start, busy, done, status, data_out, step_data and cur_step.
- Outputs: busy = (state != IDLE). step_start and done are registered pulses.
- States and transitions:
  - IDLE: on start, latch data_in into the work register, and latch the mask and the timeout limit.
    - Mask == 0: next cycle data_out=data_in, done=1, status=00, stay IDLE.
    - Otherwise: cur_step = lowest set mask bit, go to LAUNCH.
  - LAUNCH (1 cycle): step_start[cur_step]=1, clear the timeout counter, go to WAIT.
  - WAIT: only step_done[cur_step] counts. Done bits from any other step are ignored.
    - On step_done[cur_step], at the same edge: work <= step_out[cur_step] and the completed step's mask bit is cleared.
    - If enabled steps remain: cur_step = next higher set bit, go to LAUNCH.
    - If none remain: data_out <= step_out[cur_step], done=1, status=00, go to IDLE.
  - Timeout: the counter increments in each WAIT cycle without a valid done. When timeout_lim != 0 and the counter reaches timeout_lim, at that edge: data_out <= work, done=1, status=01, go to IDLE.
- Latency: start accepted at edge 0 → step_start in cycle 1. Step done at cycle k → next step_start, or done, in cycle k+1. busy falls in the same cycle done rises, so a new start is accepted in that cycle.
- abort in LAUNCH or WAIT: done=1, status=10, data_out unchanged, go to IDLE.
  - abort beats a simultaneous step_done.
  - abort beats a simultaneous timeout.
  - step_done beats a timeout reached in the same cycle.
  - abort in IDLE is ignored.
- start while busy=1 is ignored and not queued.
- Counter saturates at its maximum value. It does not wrap.

Test Plan:
- NUM_STEPS=4; each step model returns in+8'h10 three cycles after its start pulse. data_in=8'h05, mask=4'b1111 → step_start order 0,1,2,3 in cycles 1,5,9,13; done in cycle 17 with data_out=8'h45, status=00; exactly one done pulse.
- Same models, mask=4'b0101, data_in=8'h05 → only steps 0 and 2 launched; data_out=8'h25, status=00.
- mask=4'b0000, data_in=8'hA7 → done in cycle 1, data_out=8'hA7, no step_start pulse.
- Step 1 model never responds, timeout_lim=8, mask=4'b1111, data_in=8'h05 → after 8 WAIT cycles on step 1: done=1, status=01, data_out=8'h15, steps 2–3 never launched.
- abort asserted in the same cycle as step 2's done → status=10, data_out keeps its previous value. In a separate run, a spurious step_done[3] while step 1 is active → ignored, result unaffected.
- Mid-job: start re-asserted while busy → ignored. rst_n low during WAIT → all outputs 0 immediately. After reset release, a fresh start runs normally.
